// File: rtl/fifo_upsizer.sv
// ============================================================================
// Module      : fifo_upsizer
// Description : Packs RATIO show-ahead FIFO words into one wide masked word,
//               with explicit flush, idle-timeout flush and valid/ack output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_upsizer #(
    parameter int IN_WIDTH = 16,
    parameter int RATIO    = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [IN_WIDTH-1:0]          FifoQ,
    input  logic                         FifoEmpty,
    output logic                         FifoRdreq,
    input  logic                         Flush,
    output logic [IN_WIDTH*RATIO-1:0]    OutData,
    output logic [RATIO-1:0]             OutMask,
    output logic                         OutValid,
    input  logic                         OutAck,
    output logic                         Idle
);

    localparam int c_LW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int c_FW   = $clog2(RATIO + 1);
    localparam int c_OW   = IN_WIDTH * RATIO;
    localparam logic [c_LW-1:0] c_LAST = c_LW'(RATIO - 1);

    logic [c_LW-1:0]  lane_q,       lane_d;
    logic [c_OW-1:0]  asm_q,        asm_d;
    logic [c_OW-1:0]  out_data_q,   out_data_d;
    logic [RATIO-1:0] out_mask_q,   out_mask_d;
    logic             out_valid_q,  out_valid_d;
    logic             flush_pend_q, flush_pend_d;

    logic             w_last_lane;
    logic             w_out_free;
    logic             w_pop;
    logic [c_FW-1:0]  w_fill;
    logic             w_flush_eff;
    logic             w_emit;
    logic             w_tmo_hit;
    logic [c_OW-1:0]  w_asm_pop;
    logic [RATIO-1:0] w_fill_mask;

    always_comb begin
        w_last_lane = (lane_q == c_LAST);
        w_out_free  = ~out_valid_q | OutAck;
        // Gated by reset so the FIFO is never drained while held in reset.
        w_pop       = RESET & ~FifoEmpty & (~w_last_lane | w_out_free);
        w_fill      = c_FW'(lane_q) + c_FW'(w_pop);
        w_flush_eff = Flush | flush_pend_q;
        w_emit      = w_out_free & ((w_pop & w_last_lane) |
                                    (w_flush_eff & (w_fill != '0)));

        w_asm_pop = asm_q;
        for (int i = 0; i < RATIO; i++) begin
            if (w_pop && (lane_q == c_LW'(i)))
                w_asm_pop[i*IN_WIDTH +: IN_WIDTH] = FifoQ;
            w_fill_mask[i] = (c_FW'(i) < w_fill);
        end
    end

    // Assembly is cleared on emit, so lanes above the fill point stay zero.
    always_comb begin
        lane_d       = w_fill[c_LW-1:0];
        asm_d        = w_asm_pop;
        out_data_d   = out_data_q;
        out_mask_d   = out_mask_q;
        out_valid_d  = out_valid_q & ~OutAck;
        flush_pend_d = (w_flush_eff & (w_fill != '0)) | w_tmo_hit;
        if (w_emit) begin
            lane_d       = '0;
            asm_d        = '0;
            out_data_d   = w_asm_pop;
            out_mask_d   = w_fill_mask;
            out_valid_d  = 1'b1;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lane_q       <= '0;
            asm_q        <= '0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int c_TW = $clog2(TIMEOUT + 1);
            localparam logic [c_TW-1:0] c_TMO = c_TW'(TIMEOUT);
            logic [c_TW-1:0] timer_q, timer_d;

            always_comb begin
                timer_d = timer_q;
                if (w_pop || w_emit || (lane_q == '0))
                    timer_d = '0;
                else if (timer_q != c_TMO)
                    timer_d = timer_q + 1'b1;
            end

            assign w_tmo_hit = (timer_d == c_TMO);

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET)
                    timer_q <= '0;
                else
                    timer_q <= timer_d;
            end
        end else begin : g_no_timer
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    assign FifoRdreq = w_pop;
    assign OutData   = out_data_q;
    assign OutMask   = out_mask_q;
    assign OutValid  = out_valid_q;
    assign Idle      = (lane_q == '0) & ~out_valid_q & ~flush_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_upsizer.sv
// ============================================================================
// Module      : tb_fifo_upsizer
// Description : Directed bench for fifo_upsizer with a show-ahead FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_upsizer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] FifoQ;
    logic        FifoEmpty;
    logic        FifoRdreq;
    logic        Flush;
    logic [63:0] OutData;
    logic [3:0]  OutMask;
    logic        OutValid;
    logic        OutAck;
    logic        Idle;

    logic [15:0] FifoQ0;
    logic        FifoEmpty0;
    logic        FifoRdreq0;
    logic        Flush0;
    logic [63:0] OutData0;
    logic [3:0]  OutMask0;
    logic        OutValid0;
    logic        OutAck0;
    logic        Idle0;

    always #5 CLK = ~CLK;

    fifo_upsizer #(.IN_WIDTH(16), .RATIO(4), .TIMEOUT(15)) dut (
        .CLK(CLK), .RESET(RESET), .FifoQ(FifoQ), .FifoEmpty(FifoEmpty),
        .FifoRdreq(FifoRdreq), .Flush(Flush), .OutData(OutData),
        .OutMask(OutMask), .OutValid(OutValid), .OutAck(OutAck), .Idle(Idle)
    );

    fifo_upsizer #(.IN_WIDTH(16), .RATIO(4), .TIMEOUT(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .FifoQ(FifoQ0), .FifoEmpty(FifoEmpty0),
        .FifoRdreq(FifoRdreq0), .Flush(Flush0), .OutData(OutData0),
        .OutMask(OutMask0), .OutValid(OutValid0), .OutAck(OutAck0), .Idle(Idle0)
    );

    // Show-ahead FIFO model feeding the main instance.
    logic [15:0] mem [0:63];
    int wr_cnt = 0;
    int rd_cnt = 0;

    assign FifoEmpty = (wr_cnt == rd_cnt);
    assign FifoQ     = mem[rd_cnt[5:0]];

    always @(posedge CLK)
        if (FifoRdreq) rd_cnt <= rd_cnt + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_cnt[5:0]] = w;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int base;
    int lat;
    logic seen;

    initial begin
        RESET      = 1'b0;
        Flush      = 1'b0;
        OutAck     = 1'b1;
        FifoQ0     = 16'h5A5A;
        FifoEmpty0 = 1'b1;
        Flush0     = 1'b0;
        OutAck0    = 1'b1;
        push(16'hDEAD);
        #2;
        check("rst_valid", 64'(OutValid),  64'd0);
        check("rst_data",  OutData,        64'd0);
        check("rst_mask",  64'(OutMask),   64'd0);
        check("rst_idle",  64'(Idle),      64'd1);
        check("rst_rdreq", 64'(FifoRdreq), 64'd0);
        wr_cnt = rd_cnt;
        tick();
        tick();
        RESET = 1'b1;
        tick();

        // Full word, back to back
        base = rd_cnt;
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (OutValid) begin lat = k; break; end
        end
        check("full_lat",  64'(lat),           64'd4);
        check("full_data", OutData,            64'h4444_3333_2222_1111);
        check("full_mask", 64'(OutMask),       64'hF);
        check("full_pops", 64'(rd_cnt - base), 64'd4);
        tick();
        check("full_1cyc", 64'(OutValid),      64'd0);

        // Backpressure
        OutAck = 1'b0;
        base = rd_cnt;
        for (int i = 1; i <= 8; i++) push(16'(i * 16'h0101));
        repeat (12) tick();
        check("bp_pops7",  64'(rd_cnt - base), 64'd7);
        check("bp_rdreq",  64'(FifoRdreq),     64'd0);
        check("bp_valid",  64'(OutValid),      64'd1);
        check("bp_hold",   OutData,            64'h0404_0303_0202_0101);
        check("bp_mask1",  64'(OutMask),       64'hF);
        OutAck = 1'b1;
        tick();
        OutAck = 1'b0;
        check("bp_valid2", 64'(OutValid),      64'd1);
        check("bp_data2",  OutData,            64'h0808_0707_0606_0505);
        check("bp_mask2",  64'(OutMask),       64'hF);
        check("bp_pops8",  64'(rd_cnt - base), 64'd8);
        OutAck = 1'b1;
        tick();
        check("bp_drain",  64'(OutValid),      64'd0);

        // Flush partial word
        push(16'hAAAA); push(16'hBBBB);
        tick(); tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("fl_valid", 64'(OutValid), 64'd1);
        check("fl_data",  OutData,       64'h0000_0000_BBBB_AAAA);
        check("fl_mask",  64'(OutMask),  64'h3);
        tick();
        check("fl_idle",  64'(Idle),     64'd1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        tick();
        check("fl_drop",  64'(OutValid), 64'd0);

        // Pop and flush in the same cycle at lane 2
        push(16'h1234); push(16'h5678);
        tick(); tick();
        push(16'h9ABC);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("pf_mask",  64'(OutMask), 64'h7);
        check("pf_data",  OutData,      64'h0000_9ABC_5678_1234);
        tick();
        check("pf_idle",  64'(Idle),    64'd1);

        // Idle timeout
        base = rd_cnt;
        push(16'h5A5A);
        tick();
        check("tmo_pop",  64'(rd_cnt - base), 64'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (OutValid) begin lat = k; break; end
        end
        check("tmo_lat",  64'(lat),      64'd16);
        check("tmo_mask", 64'(OutMask),  64'h1);
        check("tmo_data", OutData,       64'h0000_0000_0000_5A5A);
        tick();

        // Timer disabled
        FifoEmpty0 = 1'b0;
        tick();
        FifoEmpty0 = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (OutValid0) seen = 1'b1;
        end
        check("tmo0_none", 64'(seen),     64'd0);
        check("tmo0_busy", 64'(Idle0),    64'd0);
        Flush0 = 1'b1;
        tick();
        Flush0 = 1'b0;
        check("tmo0_mask", 64'(OutMask0), 64'h1);
        check("tmo0_data", OutData0,      64'h0000_0000_0000_5A5A);
        tick();

        // Asynchronous reset mid-word
        OutAck = 1'b0;
        base = rd_cnt;
        for (int i = 1; i <= 7; i++) push(16'(16'h0A00 + i));
        repeat (8) tick();
        check("mr_pops",  64'(rd_cnt - base), 64'd7);
        check("mr_pre",   64'(OutValid),      64'd1);
        #2;
        RESET = 1'b0;
        push(16'hC001);
        #1;
        check("mr_valid", 64'(OutValid),  64'd0);
        check("mr_data",  OutData,        64'd0);
        check("mr_mask",  64'(OutMask),   64'd0);
        check("mr_idle",  64'(Idle),      64'd1);
        check("mr_rdreq", 64'(FifoRdreq), 64'd0);
        @(negedge CLK);
        RESET  = 1'b1;
        OutAck = 1'b1;
        push(16'hC002); push(16'hC003); push(16'hC004);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (OutValid) begin lat = k; break; end
        end
        check("mr_lat",   64'(lat),     64'd4);
        check("mr_word",  OutData,      64'hC004_C003_C002_C001);
        check("mr_wmask", 64'(OutMask), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_upsizer.md
# fifo_upsizer

Width-upsizing stream stage that sits directly downstream of `sc_fifo` (show-ahead mode) and drains it. It pops `IN_WIDTH`-bit words and packs `RATIO` of them into one wide output word with a per-lane mask. Partial words leave on an explicit `Flush` or an idle timeout. The output side uses a valid/ack handshake toward the wide datapath.

## Interface
- `IN_WIDTH`, 16: FIFO word width; must match the width of `sc_fifo`.
- `RATIO`, 4: input words per output word, ≥2.
- `TIMEOUT`, 15: idle cycles before an automatic flush; 0 disables the timer.
- `CLK  in  1`: single clock, rising edge.
- `RESET  in  1`: asynchronous, active-low reset.
- `FifoQ  in  IN_WIDTH`: head word of `sc_fifo` (`q`), valid whenever `~FifoEmpty`.
- `FifoEmpty  in  1`: `sc_fifo` `empty`.
- `FifoRdreq  out  1`: pop strobe to `sc_fifo` `rdreq`; combinational.
- `Flush  in  1`: one-cycle request to emit the partial word.
- `OutData  out  IN_WIDTH*RATIO`: packed word; lane 0 = bits [IN_WIDTH-1:0], first popped.
- `OutMask  out  RATIO`: bit i set = lane i holds data.
- `OutValid  out  1`: output word valid.
- `OutAck  in  1`: consumer accepts the word this cycle when `OutValid=1`.
- `Idle  out  1`: no accumulated data, no pending output, no pending flush.

## Operation
- State:
  - `Lane` (0..RATIO-1): next lane to fill.
  - Assembly register.
  - Output register plus `OutValid`.
  - `FlushPend` flag.
  - Idle timer of width $clog2(TIMEOUT+1).
- `OutFree = ~OutValid | OutAck`.
- `FifoRdreq = ~FifoEmpty & ((Lane != RATIO-1) | OutFree)`.
  - Never asserted while `FifoEmpty=1`.
  - Pop = `FifoRdreq`; `FifoQ` is captured into lane `Lane` on that edge.
- `Fill = Lane + Pop`.
- `FlushEff = Flush | FlushPend`.
- Emit condition: `OutFree & ((Pop & Lane==RATIO-1) | (FlushEff & Fill!=0))`.
- On emit:
  - The output register loads the assembly contents including this cycle's popped word.
  - Unfilled lanes are zero.
  - `OutMask` = low `Fill` bits set (all ones for a full word).
  - `OutValid` goes to 1; `Lane` goes to 0; `FlushPend` clears.
- No emit:
  - `Lane <= Fill` (wraps to 0 only through emit).
  - `FlushPend <= FlushEff & (Fill != 0)`.
  - A flush with nothing accumulated is dropped.
- `OutAck` with `OutValid=1` and no emit: `OutValid` goes to 0. With an emit in the same cycle, `OutValid` stays 1 carrying the new word.
- `OutAck` while `OutValid=0` is ignored.
- Timer:
  - Cleared on Pop, on emit, or when `Lane==0`.
  - Otherwise increments, saturating at `TIMEOUT`.
  - Reaching `TIMEOUT` sets `FlushPend`.
- `Idle = (Lane==0) & ~OutValid & ~FlushPend`.

## Timing
- Reset values:
  - `Lane=0`, `OutValid=0`, `OutData=0`, `OutMask=0`, `FlushPend=0`, timer=0.
  - `Idle=1`; `FifoRdreq=0` regardless of `FifoEmpty`.
  - Reset mid-word discards the partial data.
- Latency: `OutValid` rises on the edge that pops lane RATIO-1 (registered). It is visible the cycle after that pop.
- Throughput: one wide word per RATIO cycles with `FifoEmpty=0` and `OutAck=1`; no bubbles.
- Backpressure:
  - With `OutValid=1` and `OutAck=0`, lanes 0..RATIO-2 of the next word may still fill.
  - Popping stops at lane RATIO-1 until ack.
  - `OutData`/`OutMask` are held stable while `OutValid & ~OutAck`.
- Pop and `Flush` in the same cycle: the popped word is included in the flushed word.
- Flush while the output is blocked: `FlushPend` holds and pops continue up to lane RATIO-2. The emit fires on the first `OutFree` cycle.
- Flush together with the final-lane pop: a full word is emitted and the flush is consumed.
- Timeout: the auto-flush word emits `TIMEOUT+1` cycles after the last pop, given `OutFree`.

## Test plan
- Full word, defaults: pop 0x1111, 0x2222, 0x3333, 0x4444 back to back with `OutAck=1` -> `OutData=0x4444_3333_2222_1111`, `OutMask=4'b1111`, `OutValid` for exactly 1 cycle, one cycle after the 4th pop.
- Backpressure: 8 words available, `OutAck=0` -> exactly 7 pops, then `FifoRdreq=0`. First word is held stable. Raise `OutAck` for 1 cycle -> 8th pop, second word `OutMask=4'b1111`.
- Flush partial: pop 0xAAAA, 0xBBBB, then pulse `Flush` -> `OutData=0x0000_0000_BBBB_AAAA`, `OutMask=4'b0011`. `Flush` with `Idle=1` -> no output.
- Simultaneous pop+flush at `Lane=2` -> `OutMask=4'b0111`, the popped word in lane 2, `Lane=0` afterwards.
- Timeout: pop one word 0x5A5A, then keep `FifoEmpty=1` -> `OutMask=4'b0001` emitted 16 cycles after the pop. With `TIMEOUT=0`, no emit occurs within 100 cycles.
- Reset mid-operation: assert `RESET=0` asynchronously after 3 pops with `OutValid=1` -> all outputs return to their reset values immediately. The next 4 pops form a clean word with no stale lanes.
